uart_tx_fifo: RTL
=================

// Module: uart_tx_fifo
// PURPOSE
//  Transmit-side buffer that sits directly upstream of UART_Tx_module.
//  - Host writes bytes at clk rate.
//  - Block presents the oldest byte (first-word-fall-through) on Tx_data_o.
//  - Tx_en_o is asserted while data is pending.
//  - The Tx stage pulses tx_ack_i when it latches the byte at start-bit time; that pulse pops the FIFO.
// PARAMETERS
//  DATA_W   8    data width; must match the Tx_data_i width of UART_Tx_module
//  DEPTH    16   number of entries; power of two, >= 2
//  ADDR_W   4    log2(DEPTH); pointer width
//  AFULL_TH 12   afull_o asserts when count_o >= AFULL_TH (1..DEPTH)
// PORTS
//  clk         in   1          system clock; all logic on posedge
//  rst_n       in   1          asynchronous active-low reset
//  clr_i       in   1          synchronous flush; empties FIFO and clears overflow_o
//  wr_en_i     in   1          host write strobe, one byte per cycle high
//  wr_data_i   in   DATA_W     host write data
//  full_o      out  1          count_o == DEPTH
//  afull_o     out  1          count_o >= AFULL_TH
//  overflow_o  out  1          sticky: a write was dropped
//  tx_ack_i    in   1          1-cycle pulse from Tx stage: head byte consumed
//  Tx_en_o     out  1          data pending (== ~empty_o); drives UART_Tx_module Tx_en
//  Tx_data_o   out  DATA_W     head byte; drives UART_Tx_module Tx_data_i
//  empty_o     out  1          count_o == 0
//  count_o     out  ADDR_W+1   current occupancy, 0..DEPTH
// BEHAVIOUR
//  Reset (rst_n low, async, any time incl. mid-transfer):
//   - wr_ptr = 0, rd_ptr = 0, count_o = 0, overflow_o = 0.
//   - Outputs: empty_o = 1, full_o = 0, afull_o = 0, Tx_en_o = 0, Tx_data_o = 0.
//   - Memory array is not reset.
//  Storage:
//   - Register array mem[DEPTH].
//   - Pointers are ADDR_W bits and wrap DEPTH-1 -> 0 naturally.
//   - count_o is a registered occupancy counter, not derived from pointer difference.
//  Per-edge event decode:
//   - wr_ok = wr_en_i & (~full_o | tx_ack_i)
//   - rd_ok = tx_ack_i & ~empty_o
//  Actions at posedge:
//   - wr_ok: mem[wr_ptr] <= wr_data_i; wr_ptr++.
//   - rd_ok: rd_ptr++.
//   - count_o += wr_ok - rd_ok; write+read together leaves count_o unchanged.
//  Priority: clr_i > (wr/rd). With clr_i high:
//   - pointers, count_o and overflow_o go to 0.
//   - A write or ack in the same cycle is discarded and does not set overflow.
//  Boundary cases:
//   - Write while full with tx_ack_i high: accepted; count_o stays DEPTH.
//   - Write while full without tx_ack_i: dropped; mem and ptrs unchanged; overflow_o <= 1 (sticky until clr_i or reset).
//   - tx_ack_i while empty: ignored; no pointer or count change; no error flag.
//   - Write while empty with tx_ack_i high: ack ignored; byte stored; count_o becomes 1.
//  Latency:
//   - Byte written at edge N is visible on Tx_data_o, with Tx_en_o = 1, after edge N (same as empty_o falling).
//   - Pop at edge N presents the next byte after edge N, or drops Tx_en_o if the FIFO became empty.
//  Output decode:
//   - Tx_data_o = empty_o ? 0 : mem[rd_ptr] (combinational read, registered pointer).
//   - Flags full_o, afull_o and empty_o decode from registered count_o; glitch-free per cycle.
//  Tx stage contract:
//   - The Tx stage must hold tx_ack_i high for exactly one clk per byte.
//   - Tx_data_o is stable from Tx_en_o rise until the ack edge.
// TESTING
//  1 Reset:
//   - Stimulus: rst_n=0 with FIFO holding 5 bytes, asserted between clk edges.
//   - Response: count_o=0, empty_o=1, Tx_en_o=0 and Tx_data_o=0 immediately, without waiting for a clk edge.
//  2 Order:
//   - Stimulus: write 8'hDA,8'h3C,8'hA5; then 3 acks spaced 20 cycles.
//   - Response: Tx_data_o sequence DA,3C,A5; Tx_en_o falls after the 3rd ack.
//  3 Full/wrap:
//   - Stimulus: write 16 bytes 0..15.
//   - Response: full_o=1, afull_o=1 from count 12, count_o=16.
//   - Stimulus: 17th write.
//   - Response: dropped, overflow_o=1.
//   - Stimulus: ack x16, then write 8'h77.
//   - Response: data 0..15 in order; wr_ptr wraps; Tx_data_o=77.
//  4 Simultaneous:
//   - Stimulus: when full, write 8'hEE with ack in the same cycle.
//   - Response: count stays 16, overflow unchanged; 8'hEE emerges 16th.
//   - Stimulus: when empty, write+ack.
//   - Response: count_o=1, Tx_data_o=the written byte.
//  5 Flush:
//   - Stimulus: 6 bytes queued, overflow_o=1; clr_i with wr_en_i high.
//   - Response: count_o=0, overflow_o=0, byte discarded.
//  6 Integration:
//   - Stimulus: connect to UART_Tx_module with count_cmp baud clock; queue 8'hDA,8'h55.
//   - Response: serial line carries both frames back to back with configured parity/stop bits.

Source files
------------

// File: rtl/uart_tx_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : uart_tx_fifo
//  Purpose  : First-word-fall-through transmit buffer feeding a UART Tx stage.
//             The host pushes bytes at clk rate. The oldest byte is always
//             presented on Tx_data_o, and Tx_en_o flags that data is pending.
//             A one-cycle tx_ack_i from the Tx stage pops the head byte.
//  Revision : 1.0  initial release
// ============================================================================
module uart_tx_fifo #(
   parameter int DATA_W   = 8,
   parameter int DEPTH    = 16,
   parameter int ADDR_W   = 4,
   parameter int AFULL_TH = 12
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              clr_i,
   input  logic              wr_en_i,
   input  logic [DATA_W-1:0] wr_data_i,
   output logic              full_o,
   output logic              afull_o,
   output logic              overflow_o,
   input  logic              tx_ack_i,
   output logic              Tx_en_o,
   output logic [DATA_W-1:0] Tx_data_o,
   output logic              empty_o,
   output logic [ADDR_W:0]   count_o
);

   // Occupancy constants, sized to the counter so that every compare is
   // done at the same width.
   localparam logic [ADDR_W:0]   C_DEPTH_CNT = DEPTH[ADDR_W:0];
   localparam logic [ADDR_W:0]   C_AFULL_CNT = AFULL_TH[ADDR_W:0];
   localparam logic [ADDR_W:0]   C_CNT_ONE   = {{ADDR_W{1'b0}}, 1'b1};
   localparam logic [ADDR_W-1:0] C_PTR_ONE   = {{(ADDR_W-1){1'b0}}, 1'b1};

   // Storage and state
   logic [DATA_W-1:0] mem_q [DEPTH];

   logic [ADDR_W-1:0] wr_ptr_q,   wr_ptr_d;
   logic [ADDR_W-1:0] rd_ptr_q,   rd_ptr_d;
   logic [ADDR_W:0]   count_q,    count_d;
   logic              overflow_q, overflow_d;

   logic              full_w;
   logic              empty_w;
   logic              wr_ok;
   logic              rd_ok;
   logic              mem_we;

   // Status flags decode from the registered count only, so they cannot
   // glitch within a cycle.
   always_comb begin
      full_w  = (count_q == C_DEPTH_CNT);
      empty_w = (count_q == '0);
   end

   // Event decode. A write while full is still accepted when the head is
   // being consumed in the same cycle, because a slot frees up at that edge.
   // An ack on an empty FIFO has nothing to pop and is ignored.
   always_comb begin
      wr_ok  = wr_en_i & (~full_w | tx_ack_i);
      rd_ok  = tx_ack_i & ~empty_w;
      mem_we = wr_ok & ~clr_i;
   end

   // Next-state computation. Flush has priority and discards any write or
   // ack that arrives in the same cycle, without flagging an overflow.
   always_comb begin
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      count_d    = count_q;
      overflow_d = overflow_q;

      if (clr_i) begin
         wr_ptr_d   = '0;
         rd_ptr_d   = '0;
         count_d    = '0;
         overflow_d = 1'b0;
      end else begin
         if (wr_ok) begin
            wr_ptr_d = wr_ptr_q + C_PTR_ONE;
         end
         if (rd_ok) begin
            rd_ptr_d = rd_ptr_q + C_PTR_ONE;
         end
         case ({wr_ok, rd_ok})
            2'b10:   count_d = count_q + C_CNT_ONE;
            2'b01:   count_d = count_q - C_CNT_ONE;
            default: count_d = count_q;
         endcase
         // A dropped write is remembered until flush or reset.
         if (wr_en_i && !wr_ok) begin
            overflow_d = 1'b1;
         end
      end
   end

   // Pointer, occupancy and overflow registers with asynchronous reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         overflow_q <= 1'b0;
      end else begin
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         overflow_q <= overflow_d;
      end
   end

   // Data array. It is deliberately left out of reset: the empty flag masks
   // its contents on the output until a slot has actually been written.
   always_ff @(posedge clk) begin
      if (mem_we) begin
         mem_q[wr_ptr_q] <= wr_data_i;
      end
   end

   // Output decode. The head byte is a combinational read at the registered
   // read pointer, and it is forced to zero while the FIFO is empty.
   always_comb begin
      full_o     = full_w;
      empty_o    = empty_w;
      afull_o    = (count_q >= C_AFULL_CNT);
      overflow_o = overflow_q;
      count_o    = count_q;
      Tx_en_o    = ~empty_w;
      Tx_data_o  = empty_w ? '0 : mem_q[rd_ptr_q];
   end

endmodule
`default_nettype wire
